fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- CPU-side memory access port for the simple SoC core.
- Accepts one read or write request, tagged with a 2-bit hardware-thread ID, from the pipeline.
- Runs the request as a single bus transaction on the W_* system-bus master interface and returns the read data with a one-cycle ack pulse.
- Sits between the CPU fetch/load-store logic and the SoC interconnect.

Parameters:
- DATA_W, 32, width of the data paths.
- ADDR_W, 32, width of the address paths.
- IDLE_DATA, 32'h0000_0001, value of data_o after reset and at power-up.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- f_enable  in  1  request strobe, sampled in IDLE.
- write_mode  in  1  1 = write, 0 = read.
- addr  in  32  request address.
- data_i  in  32  write data.
- thread  in  2  thread ID of the requester.
- data_o  out  32  read result register.
- ack  out  1  one-cycle completion pulse.
- W_CLK  in  1  bus clock; must be the same net as clk; unused internally.
- W_ACK  in  1  bus acknowledge.
- W_DATA_I  in  32  bus read data.
- W_DATA_O  out  32  bus write data.
- W_ADDR  out  32  bus address.
- W_WRITE  out  1  bus write enable.
- W_STB  out  1  bus cycle strobe.

Behaviour:
- Declaration (positional) order: clk, f_enable, write_mode, addr, data_i, thread, data_o, ack, W_CLK, W_ACK, W_DATA_I, W_DATA_O, W_ADDR, W_WRITE, rst, W_STB. rst and W_STB are appended last so existing positional instances still bind.
- Single clock domain (clk). Reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: data_o = IDLE_DATA; ack = 0; W_STB = 0; W_WRITE = 0; W_ADDR = 0; W_DATA_O = 0; FSM = IDLE.
- Every register carries its reset value as its declaration/initial value, so data_o reads 32'h1 even if rst is never pulsed.
- FSM states:
  - IDLE: if f_enable == 1 (strict 1; X or 0 means no request), latch addr, data_i, write_mode and thread. Drive W_ADDR = addr, W_DATA_O = data_i (0 for a read), W_WRITE = write_mode, W_STB = 1, then go to REQ.
  - REQ: hold all bus outputs stable. When W_ACK is sampled 1: W_STB = 0, W_WRITE = 0, ack = 1; for a read, data_o = W_DATA_I; go to DONE. There is no timeout; the block waits indefinitely.
  - DONE: ack = 0; W_ADDR and W_DATA_O return to 0; go to IDLE.
- Latency:
  - Request sampled at edge N.
  - W_STB is high after edge N.
  - With W_ACK tied to 1, ack is high for exactly the cycle after edge N+1.
  - The next request is accepted at edge N+3 at the earliest.
- A write never changes data_o.
- data_o holds its value until the next read completes.
- Handshake: the requester deasserts f_enable on seeing ack. If f_enable is still 1 when the FSM returns to IDLE, a new transaction starts.
- f_enable, addr, data_i, write_mode and thread are ignored outside IDLE; only the latched thread tag is used for the transaction.
- W_ACK is ignored outside REQ.
- rst asserted in any state, including mid-REQ: on that edge, abort the transaction, force every output to its reset value and return to IDLE. The bus must tolerate the dropped W_STB.
- W_ACK and f_enable arriving in the same cycle while in REQ: complete the current transaction; the new request waits for IDLE.

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state typedef (IDLE, REQ, DONE);
  - thread ID typedef (2 bits);
  - IDLE_DATA constant.
- No sub-module: the FSM and its request latch stay in a single module.

Test Plan:
- Power-up with no rst, f_enable undriven, two clk cycles -> data_o == 32'h1, ack == 0, W_STB == 0.
- rst = 1 for one edge after arbitrary activity -> every output returns to its reset value (data_o = 32'h1).
- Read: f_enable = 1, write_mode = 0, addr = 32'h100, thread = 2; W_ACK = 1 one cycle later with W_DATA_I = 32'hDEADBEEF -> W_ADDR = 32'h100 and W_STB = 1 for one cycle, then ack pulses one cycle and data_o = 32'hDEADBEEF.
- Write: write_mode = 1, addr = 32'h200, data_i = 32'h12345678, W_ACK delayed 3 cycles -> W_ADDR, W_DATA_O and W_WRITE = 1 stable for 3 cycles; one ack pulse; data_o unchanged.
- rst asserted while in REQ -> W_STB falls on that edge; no ack; a later W_ACK is ignored.
- Back-to-back: f_enable held high across two reads -> two separate ack pulses, each separated by the DONE cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU-side memory access port.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    typedef logic [1:0] thread_id_t;

    localparam logic [31:0] IDLE_DATA = 32'h0000_0001;

endpackage

// File: rtl/fetch_unit.sv
// CPU-side memory access port: runs one tagged read/write request as a single
// bus transaction and returns read data with a one-cycle ack pulse.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] IDLE_DATA = cpu_pkg::IDLE_DATA
) (
    input  logic              clk,
    input  logic              f_enable,
    input  logic              write_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        thread,
    output logic [DATA_W-1:0] data_o,
    output logic              ack,
    input  logic              W_CLK,
    input  logic              W_ACK,
    input  logic [DATA_W-1:0] W_DATA_I,
    output logic [DATA_W-1:0] W_DATA_O,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_WRITE,
    input  logic              rst,
    output logic              W_STB
);

    // NOTE: declaration values give the reset state at power-up even if rst is
    // never pulsed; the synchronous reset below restores the same values.
    fetch_state_t      r_state  = IDLE;
    logic [DATA_W-1:0] r_data_o = IDLE_DATA;
    logic              r_ack    = 1'b0;
    logic              r_stb    = 1'b0;
    logic              r_write  = 1'b0;
    logic [ADDR_W-1:0] r_addr   = '0;
    logic [DATA_W-1:0] r_wdata  = '0;
    thread_id_t        r_thread = '0;

    fetch_state_t      w_state_nx;
    logic [DATA_W-1:0] w_data_o_nx;
    logic              w_ack_nx;
    logic              w_stb_nx;
    logic              w_write_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [DATA_W-1:0] w_wdata_nx;
    thread_id_t        w_thread_nx;

    // W_CLK is the same net as clk and the thread tag has no consumer yet.
    logic w_unused;
    assign w_unused = ^{W_CLK, r_thread};

    // NOTE: every next-value signal gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nx  = r_state;
        w_data_o_nx = r_data_o;
        w_ack_nx    = 1'b0;
        w_stb_nx    = r_stb;
        w_write_nx  = r_write;
        w_addr_nx   = r_addr;
        w_wdata_nx  = r_wdata;
        w_thread_nx = r_thread;

        case (r_state)
            IDLE: begin
                // An X strobe evaluates false here and is treated as no request.
                if (f_enable == 1'b1) begin
                    w_addr_nx   = addr;
                    w_wdata_nx  = write_mode ? data_i : '0;
                    w_write_nx  = write_mode;
                    w_thread_nx = thread;
                    w_stb_nx    = 1'b1;
                    w_state_nx  = REQ;
                end
            end
            REQ: begin
                if (W_ACK == 1'b1) begin
                    w_stb_nx   = 1'b0;
                    w_write_nx = 1'b0;
                    w_ack_nx   = 1'b1;
                    if (!r_write) begin
                        w_data_o_nx = W_DATA_I;
                    end
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_addr_nx  = '0;
                w_wdata_nx = '0;
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_data_o <= IDLE_DATA;
            r_ack    <= 1'b0;
            r_stb    <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_thread <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_data_o <= w_data_o_nx;
            r_ack    <= w_ack_nx;
            r_stb    <= w_stb_nx;
            r_write  <= w_write_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_thread <= w_thread_nx;
        end
    end

    assign data_o   = r_data_o;
    assign ack      = r_ack;
    assign W_STB    = r_stb;
    assign W_WRITE  = r_write;
    assign W_ADDR   = r_addr;
    assign W_DATA_O = r_wdata;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cases plus randomized
// transactions checked against a transaction-level expectation.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        f_enable;
    logic        write_mode;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [1:0]  thread;
    logic [31:0] data_o;
    logic        ack;
    logic        W_ACK;
    logic [31:0] W_DATA_I;
    logic [31:0] W_DATA_O;
    logic [31:0] W_ADDR;
    logic        W_WRITE;
    logic        W_STB;

    int errors = 0;
    int checks = 0;

    // Value data_o must show: last completed read, or the idle value after reset.
    logic [31:0] model_data;

    fetch_unit dut (
        .clk        (clk),
        .f_enable   (f_enable),
        .write_mode (write_mode),
        .addr       (addr),
        .data_i     (data_i),
        .thread     (thread),
        .data_o     (data_o),
        .ack        (ack),
        .W_CLK      (clk),
        .W_ACK      (W_ACK),
        .W_DATA_I   (W_DATA_I),
        .W_DATA_O   (W_DATA_O),
        .W_ADDR     (W_ADDR),
        .W_WRITE    (W_WRITE),
        .rst        (rst),
        .W_STB      (W_STB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_o"}, data_o, 32'h1);
        check({tag, "_ack"}, {31'h0, ack}, 32'h0);
        check({tag, "_stb"}, {31'h0, W_STB}, 32'h0);
        check({tag, "_write"}, {31'h0, W_WRITE}, 32'h0);
        check({tag, "_addr"}, W_ADDR, 32'h0);
        check({tag, "_wdata"}, W_DATA_O, 32'h0);
    endtask

    // One complete transaction starting from IDLE; delay = REQ cycles before W_ACK.
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] th, input int delay, input logic [31:0] rd);
        logic [31:0] exp_wdata;
        exp_wdata  = wr ? d : 32'h0;
        f_enable   = 1'b1;
        write_mode = wr;
        addr       = a;
        data_i     = d;
        thread     = th;
        W_ACK      = 1'b0;
        W_DATA_I   = $urandom;
        tick();
        check("req_stb", {31'h0, W_STB}, 32'h1);
        check("req_addr", W_ADDR, a);
        check("req_wdata", W_DATA_O, exp_wdata);
        check("req_write", {31'h0, W_WRITE}, {31'h0, wr});
        check("req_ack", {31'h0, ack}, 32'h0);
        for (int i = 0; i < delay; i++) begin
            // Request-side inputs change freely; they must be ignored in REQ.
            f_enable   = 1'($urandom_range(0, 1));
            write_mode = 1'($urandom_range(0, 1));
            addr       = $urandom;
            data_i     = $urandom;
            W_DATA_I   = $urandom;
            W_ACK      = 1'b0;
            tick();
            check("wait_stb", {31'h0, W_STB}, 32'h1);
            check("wait_addr", W_ADDR, a);
            check("wait_wdata", W_DATA_O, exp_wdata);
            check("wait_write", {31'h0, W_WRITE}, {31'h0, wr});
            check("wait_ack", {31'h0, ack}, 32'h0);
            check("wait_data_o", data_o, model_data);
        end
        f_enable = 1'b0;
        W_ACK    = 1'b1;
        W_DATA_I = rd;
        tick();
        if (!wr) model_data = rd;
        check("cpl_ack", {31'h0, ack}, 32'h1);
        check("cpl_stb", {31'h0, W_STB}, 32'h0);
        check("cpl_write", {31'h0, W_WRITE}, 32'h0);
        check("cpl_data_o", data_o, model_data);
        W_ACK    = 1'($urandom_range(0, 1));
        W_DATA_I = $urandom;
        tick();
        check("done_ack", {31'h0, ack}, 32'h0);
        check("done_addr", W_ADDR, 32'h0);
        check("done_wdata", W_DATA_O, 32'h0);
        check("done_stb", {31'h0, W_STB}, 32'h0);
        check("done_data_o", data_o, model_data);
        W_ACK = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        write_mode = 1'b0;
        addr       = 32'h0;
        data_i     = 32'h0;
        thread     = 2'd0;
        W_ACK      = 1'b0;
        W_DATA_I   = 32'h0;
        model_data = 32'h1;

        // Power-up without reset, f_enable never driven.
        tick();
        tick();
        check_reset_outputs("powerup");

        // Some activity, then a one-edge reset.
        run_txn(1'b0, 32'h40, 32'h0, 2'd1, 1, 32'hA5A5_0F0F);
        f_enable = 1'b1;
        addr     = 32'h44;
        tick();
        f_enable = 1'b0;
        rst      = 1'b1;
        tick();
        rst        = 1'b0;
        model_data = 32'h1;
        check_reset_outputs("reset");

        // Directed read, ack one cycle later.
        run_txn(1'b0, 32'h100, 32'h0, 2'd2, 0, 32'hDEAD_BEEF);
        check("read_data_o", data_o, 32'hDEAD_BEEF);

        // Directed write, ack delayed three cycles; data_o must hold.
        run_txn(1'b1, 32'h200, 32'h1234_5678, 2'd0, 3, 32'hFFFF_0000);
        check("write_data_o", data_o, 32'hDEAD_BEEF);

        // Reset in the middle of REQ, then a stray W_ACK.
        f_enable   = 1'b1;
        write_mode = 1'b0;
        addr       = 32'h300;
        tick();
        f_enable = 1'b0;
        check("abort_stb_pre", {31'h0, W_STB}, 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        model_data = 32'h1;
        check_reset_outputs("abort");
        W_ACK    = 1'b1;
        W_DATA_I = 32'hBAD0_BAD0;
        tick();
        check("abort_late_ack", {31'h0, ack}, 32'h0);
        check("abort_late_data_o", data_o, 32'h1);
        tick();
        W_ACK = 1'b0;
        check("abort_late_ack2", {31'h0, ack}, 32'h0);
        check("abort_late_stb", {31'h0, W_STB}, 32'h0);

        // Back-to-back reads with f_enable and W_ACK held high.
        f_enable   = 1'b1;
        write_mode = 1'b0;
        addr       = 32'h500;
        W_ACK      = 1'b1;
        W_DATA_I   = 32'h1111_2222;
        tick();
        check("b2b_stb1", {31'h0, W_STB}, 32'h1);
        check("b2b_addr1", W_ADDR, 32'h500);
        check("b2b_ack_n", {31'h0, ack}, 32'h0);
        tick();
        check("b2b_ack1", {31'h0, ack}, 32'h1);
        check("b2b_data1", data_o, 32'h1111_2222);
        addr     = 32'h504;
        W_DATA_I = 32'h3333_4444;
        tick();
        check("b2b_done_ack", {31'h0, ack}, 32'h0);
        check("b2b_done_stb", {31'h0, W_STB}, 32'h0);
        tick();
        check("b2b_stb2", {31'h0, W_STB}, 32'h1);
        check("b2b_addr2", W_ADDR, 32'h504);
        check("b2b_ack_gap", {31'h0, ack}, 32'h0);
        tick();
        f_enable = 1'b0;
        W_ACK    = 1'b0;
        check("b2b_ack2", {31'h0, ack}, 32'h1);
        check("b2b_data2", data_o, 32'h3333_4444);
        model_data = 32'h3333_4444;
        tick();
        check("b2b_end_ack", {31'h0, ack}, 32'h0);
        tick();
        check("b2b_end_stb", {31'h0, W_STB}, 32'h0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom),
                    int'($urandom_range(0, 4)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check("rnd_idle_stb", {31'h0, W_STB}, 32'h0);
                check("rnd_idle_data_o", data_o, model_data);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
